game_ctrl: RTL and testbench
============================

# game_ctrl

Per-frame game supervisor between the player/enemy position blocks and the renderer. Once per VGA frame it samples the player and enemy positions, tests them for overlap, and runs the game state machine. It drives `game_state`, `p1_score` and `player_dead`, which the renderer consumes.

## Interface
- `PLAYER_W`, 32: player box width in pixels
- `PLAYER_H`, 32: player box height in pixels
- `ENEMY_W`, 32: enemy box width in pixels
- `ENEMY_H`, 32: enemy box height in pixels
- `SURVIVE_FRAMES`, 60: frames survived in PLAY per score point (≥1)
- `DEAD_FRAMES`, 120: frames held in DEAD before leaving it (≥1)
- `SCORE_MAX`, 9: score that triggers WIN (1..15)
- `clk` in 1: system clock; the only clock
- `reset` in 1: asynchronous, active-low reset
- `button` in 1: start/restart button, asynchronous to `clk`
- `x` in 16: current raster column from the VGA timing block
- `y` in 16: current raster row from the VGA timing block
- `x_player`, `y_player` in 16 each: player top-left corner
- `x_enemy`, `y_enemy` in 16 each: enemy top-left corner
- `game_state` out 2: 00 IDLE, 01 PLAY, 10 DEAD, 11 WIN
- `p1_score` out 4: current score
- `player_dead` out 1: high while in DEAD
- `lives` out 2: remaining lives (see Configuration)

## Operation
- **Button path**
  - Two-flop synchroniser, then a rising-edge detect, gives `press`, a 1-cycle pulse.
  - Holding the button produces exactly one `press`.
- **Frame tick**
  - `origin = (x==0 && y==0)`.
  - `frame` is a 1-cycle pulse on the rising edge of `origin`, so a multi-cycle origin pixel yields one tick.
- **Sampling and overlap**
  - On `frame`, latch all four position inputs.
  - Next cycle, register `hit`, computed in 17-bit arithmetic (no wrap):
    - `x_p < x_e+ENEMY_W`, and
    - `x_e < x_p+PLAYER_W`, and
    - `y_p < y_e+ENEMY_H`, and
    - `y_e < y_p+PLAYER_H`.
  - Edge-touching boxes, e.g. `x_p+PLAYER_W == x_e`, are not a hit.
- **State machine** (the state update is the evaluation step, 2 cycles after `frame`)
  - IDLE:
    - on `press`: go to PLAY, clear score, clear survival counter, load lives.
  - PLAY, at each evaluation:
    - if `hit`: go to DEAD and clear the frame counter; the score does not change.
    - else: increment the survival counter. When it reaches `SURVIVE_FRAMES`, clear it and increment the score.
    - when the score becomes `SCORE_MAX`: go to WIN.
  - DEAD:
    - count frames; after `DEAD_FRAMES` frames go to IDLE.
    - `press` is ignored.
  - WIN:
    - on `press`: go to PLAY with score cleared.
- **Simultaneous events**
  - `hit` in the same evaluation as a score increment: hit wins, no increment.
  - `press` coinciding with an evaluation in IDLE/WIN: the PLAY entry happens; that evaluation is discarded.
- **Score**
  - Saturates at `SCORE_MAX` and never wraps.
  - Holds its value through DEAD, IDLE and WIN until the next game start.

## Timing
- Reset (asynchronous assert, any cycle, including mid-game):
  - `game_state`=00, `p1_score`=0, `player_dead`=0.
  - `lives` = reset value in Configuration.
  - All counters, latches and synchroniser flops = 0.
- Release is synchronous to `clk`. The first possible `frame` is on the first origin edge after release.
- `press` follows the `button` edge by 3 cycles.
- State change follows `press` by 1 cycle.
- Position latch at cycle F (`frame`); `hit` valid at F+1; state/score/`player_dead` update at F+2.
- All outputs are registered; no combinational path from inputs to outputs.
- Positions changing between frames have no effect until the next `frame`.

## Configuration
- `GAME_CTRL_LIVES_EN`:
  - **Defined:**
    - lives load 3 on game start, reset value 3.
    - DEAD decrements lives on entry.
    - On DEAD expiry, go to PLAY with score kept if lives > 0, else go to IDLE.
  - **Undefined:**
    - single life; DEAD always expires to IDLE.
    - `lives` tied to 0.

## Test plan
- Reset mid-PLAY with score 5 -> next cycle `game_state`=00, `p1_score`=0, `player_dead`=0.
- IDLE, `button` held high 1000 cycles -> exactly one transition to 01; no retrigger.
- PLAY, boxes apart (player 0,0; enemy 100,100), `SURVIVE_FRAMES`=2, `SCORE_MAX`=3 -> score 1,2,3 at frames 2,4,6; `game_state`=11 at frame 6.
- Player (0,0), enemy (31,0) -> DEAD at F+2 with `player_dead`=1. Enemy at (32,0) -> no hit.
- Hit on the same frame as a due score increment -> DEAD, score unchanged. With `DEAD_FRAMES`=4, back to IDLE after 4 frames.
- With `GAME_CTRL_LIVES_EN`: three hits -> `lives` 2,1,0; PLAY resumes twice with score kept; IDLE after the third.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl: per-frame game supervisor (overlap test + IDLE/PLAY/DEAD/WIN FSM).
// Define GAME_CTRL_LIVES_EN for three lives; otherwise single life and lives tied to 0.
module game_ctrl #(
  parameter int PLAYER_W       = 32,
  parameter int PLAYER_H       = 32,
  parameter int ENEMY_W        = 32,
  parameter int ENEMY_H        = 32,
  parameter int SURVIVE_FRAMES = 60,
  parameter int DEAD_FRAMES    = 120,
  parameter int SCORE_MAX      = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        button,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] x_player,
  input  logic [15:0] y_player,
  input  logic [15:0] x_enemy,
  input  logic [15:0] y_enemy,
  output logic [1:0]  game_state,
  output logic [3:0]  p1_score,
  output logic        player_dead,
  output logic [1:0]  lives
);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, DEAD = 2'b10, WIN = 2'b11} state_t;
`ifdef GAME_CTRL_LIVES_EN
  localparam logic [1:0] LIVES_INIT = 2'd3;
`else
  localparam logic [1:0] LIVES_INIT = 2'd0;
`endif
  localparam logic [15:0] SF = 16'(SURVIVE_FRAMES);
  localparam logic [15:0] DF = 16'(DEAD_FRAMES);
  localparam logic [3:0]  SM = 4'(SCORE_MAX);
  state_t      state, state_n;
  logic        s1, s2, s3, press, origin, origin_d, frame, f1, eval, hit, overlap;
  logic [15:0] xp, yp, xe, ye, surv, surv_n, dcnt, dcnt_n;
  logic [3:0]  score_n;
  logic [1:0]  lives_n;
  assign origin = x == 16'd0 && y == 16'd0;
  assign frame  = origin && !origin_d;
  // 17-bit compares so boxes near the 16-bit limit do not wrap
  assign overlap = ({1'b0, xp} < {1'b0, xe} + 17'(ENEMY_W))  &&
                   ({1'b0, xe} < {1'b0, xp} + 17'(PLAYER_W)) &&
                   ({1'b0, yp} < {1'b0, ye} + 17'(ENEMY_H))  &&
                   ({1'b0, ye} < {1'b0, yp} + 17'(PLAYER_H));
  assign game_state = state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {s1, s2, s3, press, origin_d, f1, eval, hit} <= '0;
      {xp, yp, xe, ye} <= '0;
      state       <= IDLE;
      p1_score    <= '0;
      surv        <= '0;
      dcnt        <= '0;
      lives       <= LIVES_INIT;
      player_dead <= 1'b0;
    end else begin
      {s3, s2, s1} <= {s2, s1, button};
      press        <= s2 && !s3;
      origin_d     <= origin;
      f1           <= frame;
      eval         <= f1;
      if (frame) {xp, yp, xe, ye} <= {x_player, y_player, x_enemy, y_enemy};
      hit          <= overlap;
      state        <= state_n;
      p1_score     <= score_n;
      surv         <= surv_n;
      dcnt         <= dcnt_n;
      lives        <= lives_n;
      player_dead  <= state_n == DEAD;
    end
  always_comb begin
    state_n = state;
    score_n = p1_score;
    surv_n  = surv;
    dcnt_n  = dcnt;
    lives_n = lives;
    case (state)
      IDLE, WIN: if (press) begin
        state_n = PLAY;
        score_n = '0;
        surv_n  = '0;
        lives_n = LIVES_INIT;
      end
      PLAY: if (eval) begin
        if (hit) begin
          state_n = DEAD;
          dcnt_n  = '0;
          lives_n = lives - 2'(lives != 2'd0);
        end else if (surv + 16'd1 == SF) begin
          surv_n  = '0;
          score_n = p1_score + 4'(p1_score != SM);
          state_n = score_n == SM ? WIN : PLAY;
        end else surv_n = surv + 16'd1;
      end
      DEAD: if (eval) begin
        dcnt_n = dcnt + 16'd1;
        if (dcnt_n == DF) begin
          state_n = lives != 2'd0 ? PLAY : IDLE;
          surv_n  = '0;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed plus randomized frames checked against a frame-level game model.
module tb_game_ctrl;
  localparam int SF = 2, DF = 4, SM = 3, BOX = 32;
  localparam int IDLE = 0, PLAY = 1, DEAD = 2, WIN = 3;
`ifdef GAME_CTRL_LIVES_EN
  localparam int LIVES0 = 3;
`else
  localparam int LIVES0 = 0;
`endif
  logic clk = 0, reset = 0, button = 0;
  logic [15:0] x = 16'd3, y = 16'd2, x_player = 0, y_player = 0, x_enemy = 0, y_enemy = 0;
  logic [1:0] game_state, lives;
  logic [3:0] p1_score;
  logic player_dead;
  int total = 0, bad = 0;
  int m_state, m_score, m_surv, m_dead, m_lives;
  always #5 clk = ~clk;
  game_ctrl #(.SURVIVE_FRAMES(SF), .DEAD_FRAMES(DF), .SCORE_MAX(SM)) dut (
    .clk(clk), .reset(reset), .button(button), .x(x), .y(y),
    .x_player(x_player), .y_player(y_player), .x_enemy(x_enemy), .y_enemy(y_enemy),
    .game_state(game_state), .p1_score(p1_score), .player_dead(player_dead), .lives(lives)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp)) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, "_state"}, 32'(game_state), m_state);
    chk({tag, "_score"}, 32'(p1_score), m_score);
    chk({tag, "_dead"}, 32'(player_dead), int'(m_state == DEAD));
    chk({tag, "_lives"}, 32'(lives), m_lives);
  endtask
  function automatic void m_reset();
    m_state = IDLE; m_score = 0; m_surv = 0; m_dead = 0; m_lives = LIVES0;
  endfunction
  function automatic void m_start();
    m_state = PLAY; m_score = 0; m_surv = 0; m_lives = LIVES0;
  endfunction
  function automatic bit overlaps(input int xp, input int yp, input int xe, input int ye);
    return xp < xe + BOX && xe < xp + BOX && yp < ye + BOX && ye < yp + BOX;
  endfunction
  // One evaluation of the game rules for a frame whose overlap result is h
  function automatic void m_eval(input bit h);
    if (m_state == PLAY) begin
      if (h) begin
        m_state = DEAD; m_dead = 0;
        if (m_lives > 0) m_lives--;
      end else if (++m_surv == SF) begin
        m_surv = 0;
        if (m_score < SM) m_score++;
        if (m_score == SM) m_state = WIN;
      end
    end else if (m_state == DEAD) begin
      if (++m_dead == DF) begin
        m_state = m_lives > 0 ? PLAY : IDLE;
        m_surv = 0;
      end
    end
  endfunction
  task automatic frame_step(input logic [15:0] xp, input logic [15:0] yp,
                            input logic [15:0] xe, input logic [15:0] ye);
    int pre;
    bit h;
    pre = m_state;
    h = overlaps(int'(xp), int'(yp), int'(xe), int'(ye));
    x_player = xp; y_player = yp; x_enemy = xe; y_enemy = ye; x = 0; y = 0;
    @(negedge clk);
    x_player = 16'($urandom); y_player = 16'($urandom);
    x_enemy = 16'($urandom); y_enemy = 16'($urandom);
    @(negedge clk);
    chk("pre_eval", 32'(game_state), pre);
    x = 16'($urandom_range(0, 1));
    @(negedge clk);
    m_eval(h);
    check_all("frame");
    x = 16'd3; y = 16'd2;
    @(negedge clk);
  endtask
  task automatic press_btn(input int hold);
    int pre;
    pre = m_state;
    button = 1;
    repeat (3) @(negedge clk);
    chk("press_wait", 32'(game_state), pre);
    @(negedge clk);
    if (m_state == IDLE || m_state == WIN) m_start();
    check_all("press");
    repeat (hold) @(negedge clk);
    button = 0;
    repeat (4) @(negedge clk);
    check_all("press_rel");
  endtask
  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    reset = 1;
    repeat (2) @(negedge clk);
    frame_step(0, 0, 10, 10);
    press_btn(1000);
    for (int i = 0; i < 6; i++) frame_step(0, 0, 100, 100);
    chk("win_reached", 32'(game_state), WIN);
    button = 1;
    @(negedge clk);
    x_player = 0; y_player = 0; x_enemy = 100; y_enemy = 100; x = 0; y = 0;
    repeat (2) @(negedge clk);
    chk("press_eval_wait", 32'(game_state), WIN);
    @(negedge clk);
    m_start();
    check_all("press_eval");
    x = 16'd3; y = 16'd2;
    @(negedge clk);
    button = 0;
    repeat (4) @(negedge clk);
    frame_step(0, 0, 100, 100);
    frame_step(0, 0, 100, 100);
    frame_step(0, 0, 32, 0);
    frame_step(0, 0, 31, 0);
    chk("hit_on_due", 32'(p1_score), 1);
    frame_step(0, 0, 100, 100);
    press_btn(2);
    for (int i = 0; i < 3; i++) frame_step(0, 0, 100, 100);
    while (m_state != PLAY) begin
      if (m_state == DEAD) frame_step(0, 0, 200, 200);
      else press_btn(1);
    end
    frame_step(16'd65530, 0, 16'd65535, 0);
    for (int i = 0; i < 60; i++) begin
      if ((m_state == IDLE || m_state == WIN) && $urandom_range(0, 1) == 1)
        press_btn($urandom_range(1, 5));
      else
        frame_step(16'($urandom_range(0, 120)), 16'($urandom_range(0, 120)),
                   16'($urandom_range(0, 120)), 16'($urandom_range(0, 120)));
    end
    while (m_state != PLAY) begin
      if (m_state == DEAD) frame_step(0, 0, 200, 200);
      else press_btn(1);
    end
    frame_step(0, 0, 100, 100);
    #2 reset = 0;
    m_reset();
    #1 check_all("async_reset");
    @(negedge clk);
    check_all("reset_hold");
    reset = 1;
    @(negedge clk);
    frame_step(0, 0, 100, 100);
    press_btn(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
